ahb_lite_master: RTL and testbench

- Command-driven AHB-Lite initiator. Converts simple word-burst commands into AHB transfers (htrans/haddr/hburst/hwdata) and returns read data.
- Drives the AHB SRAM subsystem (hclk/hresetn domain, 0x00000000–0x00003FFC) from test/DMA logic.
- Handles pipelined address/data phases, hready wait states, 1KB boundary splitting and two-cycle ERROR responses.

---
 rtl/ahb_lite_master.sv | 146 ++++++++++++++
 tb/tb_ahb_lite_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// Command-driven AHB-Lite initiator: turns word-burst commands into pipelined
// AHB transfers, splits bursts at 1KB boundaries and handles two-cycle ERROR responses.
module ahb_lite_master #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      wr_data,
   output logic             wr_pop,
   output logic             rd_valid,
   output logic [31:0]      rd_data,
   output logic             done,
   output logic             done_err,
   output logic [1:0]       htrans,
   output logic [31:0]      haddr,
   output logic             hwrite,
   output logic [2:0]       hsize,
   output logic [2:0]       hburst,
   output logic [31:0]      hwdata,
   input  logic             hready,
   input  logic [1:0]       hresp,
   input  logic [31:0]      hrdata
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE, S_ERR1
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       htrans_q;
   logic [LEN_W-1:0] addr_left, data_cnt, len_q, len_eff;
   logic             err_q;
   logic [31:0]      haddr_nxt;
   logic             accept, addr_ph, data_ph, err_now, addr_adv, data_ok, data_fin;

   // zero means one beat; oversize requests are clamped to MAX_LEN
   always_comb begin
      len_eff = cmd_len;
      if (cmd_len == '0)
         len_eff = LEN_W'(1);
      else if (cmd_len > LEN_W'(MAX_LEN))
         len_eff = LEN_W'(MAX_LEN);
   end

   assign accept    = cmd_valid && (state == S_IDLE);
   assign addr_ph   = (state == S_ADDR) || (state == S_BURST);
   assign data_ph   = (state == S_BURST) || (state == S_LAST);
   assign err_now   = data_ph && (hresp == RESP_ERR);
   assign addr_adv  = addr_ph && hready && !err_now;
   assign data_ok   = data_ph && hready && !err_now;
   assign data_fin  = data_ok && ((data_cnt + LEN_W'(1)) == len_q);
   assign haddr_nxt = haddr + 32'd4;

   assign cmd_ready = (state == S_IDLE);
   assign wr_pop    = addr_adv && hwrite;
   assign done      = (state == S_DONE);
   assign done_err  = (state == S_DONE) && err_q;
   assign hsize     = 3'b010;
   // first ERROR cycle cancels the pending address phase before the register catches up
   assign htrans    = err_now ? TR_IDLE : htrans_q;

   always_ff @(posedge hclk) begin
      if (!hresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_ADDR;
         S_ADDR:  if (addr_adv) state_nxt = (addr_left == LEN_W'(1)) ? S_LAST : S_BURST;
         S_BURST: begin
            if (err_now)       state_nxt = hready ? S_DONE : S_ERR1;
            else if (addr_adv) state_nxt = (addr_left == LEN_W'(1)) ? S_LAST : S_BURST;
         end
         S_LAST: begin
            if (err_now)       state_nxt = hready ? S_DONE : S_ERR1;
            else if (data_fin) state_nxt = S_DONE;
         end
         S_ERR1:  if (hready) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         htrans_q  <= TR_IDLE;
         haddr     <= '0;
         hwrite    <= 1'b0;
         hburst    <= 3'b000;
         hwdata    <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         addr_left <= '0;
         data_cnt  <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (accept) begin
            haddr     <= {cmd_addr[31:2], 2'b00};
            htrans_q  <= TR_NONSEQ;
            hwrite    <= cmd_write;
            hburst    <= (len_eff == LEN_W'(1)) ? 3'b000 : 3'b001;
            addr_left <= len_eff;
            len_q     <= len_eff;
            data_cnt  <= '0;
            err_q     <= 1'b0;
         end
         if (addr_adv) begin
            addr_left <= addr_left - LEN_W'(1);
            if (addr_left == LEN_W'(1)) begin
               htrans_q <= TR_IDLE;
            end else begin
               haddr    <= haddr_nxt;
               htrans_q <= (haddr_nxt[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
            end
            if (hwrite) hwdata <= wr_data;
         end
         if (data_ok) begin
            data_cnt <= data_cnt + LEN_W'(1);
            if (!hwrite) begin
               rd_valid <= 1'b1;
               rd_data  <= hrdata;
            end
         end
         if (err_now) begin
            htrans_q <= TR_IDLE;
            err_q    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: cycle-by-cycle bus checks with a scripted slave.
module tb_ahb_lite_master;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [4:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_pop, rd_valid, done, done_err;
   logic [31:0] rd_data;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [31:0] hwdata;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   int rvs   = 0;
   int p0, r0;

   ahb_lite_master #(.MAX_LEN(16), .LEN_W(5)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_pop(wr_pop),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .done(done), .done_err(done_err),
      .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   always #5 hclk = ~hclk;

   always @(posedge hclk) begin
      if (wr_pop)   pops <= pops + 1;
      if (rd_valid) rvs  <= rvs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic bus(input string tag, input logic [1:0] tr, input logic [31:0] a);
      chk({tag, " htrans"}, 32'(htrans), 32'(tr));
      chk({tag, " haddr"}, haddr, a);
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic cmd(input logic w, input logic [31:0] a, input logic [4:0] l);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
   endtask

   initial begin
      hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; hready = 1'b1; hresp = 2'b00; hrdata = '0;

      // reset state
      repeat (2) @(posedge hclk);
      #1;
      bus("rst", 2'b00, 32'h0);
      chk("rst hwdata", hwdata, 0);
      chk("rst hburst", 32'(hburst), 0);
      chk("rst hwrite", 32'(hwrite), 0);
      chk("rst rd_valid", 32'(rd_valid), 0);
      chk("rst rd_data", rd_data, 0);
      chk("rst done", 32'(done), 0);
      chk("rst wr_pop", 32'(wr_pop), 0);
      hresetn = 1'b1;
      #1;
      chk("rst cmd_ready", 32'(cmd_ready), 1);
      chk("hsize", 32'(hsize), 32'h2);

      // single write
      cmd(1'b1, 32'h10, 5'd1); wr_data = 32'hDEADBEEF;
      tick(); cmd_valid = 1'b0; #1;
      bus("t1 a", 2'b10, 32'h10);
      chk("t1 hburst", 32'(hburst), 0);
      chk("t1 hwrite", 32'(hwrite), 1);
      chk("t1 wr_pop", 32'(wr_pop), 1);
      tick();
      chk("t1 d htrans", 32'(htrans), 0);
      chk("t1 hwdata", hwdata, 32'hDEADBEEF);
      chk("t1 d wr_pop", 32'(wr_pop), 0);
      chk("t1 d done", 32'(done), 0);
      tick();
      chk("t1 done", 32'(done), 1);
      chk("t1 done_err", 32'(done_err), 0);
      chk("t1 busy", 32'(cmd_ready), 0);
      tick();
      chk("t1 idle rdy", 32'(cmd_ready), 1);

      // 4-beat read, two wait states on beat 2
      r0 = rvs;
      cmd(1'b0, 32'h100, 5'd4);
      tick(); cmd_valid = 1'b0; #1;
      bus("t2 b1", 2'b10, 32'h100);
      chk("t2 hburst", 32'(hburst), 1);
      tick(); hrdata = 32'hA1; #1;
      bus("t2 b2", 2'b11, 32'h104);
      tick(); hready = 1'b0; hrdata = 32'hX; #1;
      bus("t2 b3", 2'b11, 32'h108);
      chk("t2 rv1", 32'(rd_valid), 1);
      chk("t2 rd1", rd_data, 32'hA1);
      tick();
      bus("t2 wait", 2'b11, 32'h108);
      chk("t2 wait rv", 32'(rd_valid), 0);
      tick(); hready = 1'b1; hrdata = 32'hA2; #1;
      bus("t2 b3 held", 2'b11, 32'h108);
      tick(); hrdata = 32'hA3; #1;
      bus("t2 b4", 2'b11, 32'h10C);
      chk("t2 rd2", rd_data, 32'hA2);
      tick(); hrdata = 32'hA4; #1;
      chk("t2 last htrans", 32'(htrans), 0);
      chk("t2 rd3", rd_data, 32'hA3);
      tick();
      chk("t2 rd4", rd_data, 32'hA4);
      chk("t2 rv4", 32'(rd_valid), 1);
      chk("t2 done", 32'(done), 1);
      chk("t2 rv count", 32'(rvs - r0 + 1), 4);
      tick();

      // 4-beat write across 1KB boundary
      p0 = pops;
      cmd(1'b1, 32'h3F8, 5'd4); wr_data = 32'hB0;
      tick(); cmd_valid = 1'b0; #1;
      bus("t3 b1", 2'b10, 32'h3F8);
      tick(); wr_data = 32'hB1; #1;
      bus("t3 b2", 2'b11, 32'h3FC);
      chk("t3 hwdata0", hwdata, 32'hB0);
      tick(); wr_data = 32'hB2; #1;
      bus("t3 b3 split", 2'b10, 32'h400);
      chk("t3 hwdata1", hwdata, 32'hB1);
      tick(); wr_data = 32'hB3; #1;
      bus("t3 b4", 2'b11, 32'h404);
      chk("t3 hwdata2", hwdata, 32'hB2);
      tick();
      chk("t3 last htrans", 32'(htrans), 0);
      chk("t3 hwdata3", hwdata, 32'hB3);
      chk("t3 last pop", 32'(wr_pop), 0);
      tick();
      chk("t3 done", 32'(done), 1);
      chk("t3 pop count", 32'(pops - p0), 4);
      tick();

      // 8-beat read, ERROR on beat 3
      r0 = rvs;
      cmd(1'b0, 32'h200, 5'd8);
      tick(); cmd_valid = 1'b0; #1;
      tick(); hrdata = 32'hC1; #1;
      tick(); hrdata = 32'hC2; #1;
      tick(); hready = 1'b0; hresp = 2'b01; #1;
      chk("t4 err htrans", 32'(htrans), 0);
      tick(); hready = 1'b1; #1;
      chk("t4 err1 htrans", 32'(htrans), 0);
      tick(); hresp = 2'b00; #1;
      chk("t4 done", 32'(done), 1);
      chk("t4 done_err", 32'(done_err), 1);
      chk("t4 no rv", 32'(rd_valid), 0);
      chk("t4 busy", 32'(cmd_ready), 0);
      chk("t4 rv count", 32'(rvs - r0), 2);
      tick();
      chk("t4 ready", 32'(cmd_ready), 1);
      chk("t4 done off", 32'(done), 0);

      // reset during beat 2 of a 4-beat write
      cmd(1'b1, 32'h40, 5'd4); wr_data = 32'hD0;
      tick(); cmd_valid = 1'b0; #1;
      tick(); hresetn = 1'b0; wr_data = 32'hD1; #1;
      tick();
      bus("t5 rst", 2'b00, 32'h0);
      chk("t5 done", 32'(done), 0);
      chk("t5 hwdata", hwdata, 0);
      hresetn = 1'b1;
      cmd(1'b0, 32'h20, 5'd1);
      #1;
      chk("t5 ready", 32'(cmd_ready), 1);
      tick(); cmd_valid = 1'b0; #1;
      bus("t5 rd", 2'b10, 32'h20);
      chk("t5 hwrite", 32'(hwrite), 0);
      tick(); hrdata = 32'h1234; #1;
      tick();
      chk("t5 done", 32'(done), 1);
      chk("t5 rd_data", rd_data, 32'h1234);
      tick();

      // back-to-back: second command waits for IDLE; len 0 means one beat
      cmd(1'b1, 32'h80, 5'd2); wr_data = 32'hE1;
      tick(); cmd(1'b0, 32'h90, 5'd0); #1;
      chk("t6 c1 busy", 32'(cmd_ready), 0);
      bus("t6 c1", 2'b10, 32'h80);
      tick(); wr_data = 32'hE2; #1;
      chk("t6 hwdata1", hwdata, 32'hE1);
      tick();
      chk("t6 hwdata2", hwdata, 32'hE2);
      chk("t6 c3 busy", 32'(cmd_ready), 0);
      tick();
      chk("t6 done1", 32'(done), 1);
      chk("t6 c4 busy", 32'(cmd_ready), 0);
      tick();
      chk("t6 accept", 32'(cmd_ready), 1);
      tick(); cmd_valid = 1'b0; #1;
      bus("t6 c2", 2'b10, 32'h90);
      chk("t6 single", 32'(hburst), 0);
      tick(); hrdata = 32'hBEEF0090; #1;
      tick();
      chk("t6 done2", 32'(done), 1);
      chk("t6 rd_data", rd_data, 32'hBEEF0090);
      tick();

      // address wrap at top of map, low bits forced to zero
      cmd(1'b0, 32'hFFFFFFFF, 5'd2);
      tick(); cmd_valid = 1'b0; #1;
      bus("t7 b1", 2'b10, 32'hFFFFFFFC);
      tick();
      bus("t7 wrap", 2'b10, 32'h0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
         end
         chk("t7 done seen", 32'(seen), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
